// File: rtl/wb_commit_pkg.sv
// Shared types and constants for the writeback commit buffer.
package wb_commit_pkg;

    localparam logic [3:0]  ADDR_PC = 4'd15;
    localparam int unsigned ENTRY_W = 70;

    // Packed layout: data[31:0], addr[35:32], reg_en[36], cpsr[68:37], cpsr_en[69]
    typedef struct packed {
        logic        cpsr_en;
        logic [31:0] cpsr;
        logic        reg_en;
        logic [3:0]  addr;
        logic [31:0] data;
    } wb_entry_t;

    // An entry that writes neither a register nor CPSR carries no work.
    function automatic logic entry_live(input wb_entry_t e);
        return e.reg_en | e.cpsr_en;
    endfunction

    // A queued PC write must wait while fetch is updating the PC this cycle.
    function automatic logic pc_conflict(input wb_entry_t e, input logic pc_valid);
        return e.reg_en && (e.addr == ADDR_PC) && pc_valid;
    endfunction

endpackage

// File: rtl/wb_commit_if.sv
// Writeback-to-commit handshake bundle.
interface wb_commit_if;

    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic [3:0]  wb_addr;
    logic        wb_reg_en;
    logic [31:0] wb_cpsr;
    logic        wb_cpsr_en;

    modport master (
        output wb_valid, wb_data, wb_addr, wb_reg_en, wb_cpsr, wb_cpsr_en,
        input  wb_ready
    );

    modport slave (
        input  wb_valid, wb_data, wb_addr, wb_reg_en, wb_cpsr, wb_cpsr_en,
        output wb_ready
    );

endinterface

// File: rtl/wb_commit_fifo.sv
// Circular buffer for commit entries; exposes storage for the bypass query.
module wb_commit_fifo
    import wb_commit_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 3,
    parameter int unsigned W     = ENTRY_W,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push_i,
    input  logic [W-1:0]              push_data_i,
    input  logic                      pop_i,
    output logic [W-1:0]              head_data_o,
    output logic [PTR_W-1:0]          head_o,
    output logic [CNT_W-1:0]          count_o,
    output logic [DEPTH-1:0]          valid_o,
    output logic [DEPTH-1:0][W-1:0]   entries_o
);

    logic [DEPTH-1:0][W-1:0] mem_q;
    logic [DEPTH-1:0]        valid_q, valid_d;
    logic [PTR_W-1:0]        head_q, head_d;
    logic [PTR_W-1:0]        tail_q, tail_d;
    logic [CNT_W-1:0]        count_q, count_d;

    // Pointer, occupancy and valid-bit bookkeeping for push/pop.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        if (pop_i) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end
        if (push_i) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + 1'b1;
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Entry storage; contents are qualified by valid bits, so no reset needed.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[tail_q] <= push_data_i;
        end
    end

    assign head_data_o = mem_q[head_q];
    assign head_o      = head_q;
    assign count_o     = count_q;
    assign valid_o     = valid_q;
    assign entries_o   = mem_q;

endmodule

// File: rtl/wb_commit.sv
// Commit buffer between writeback and the register bank, with bypass query.
module wb_commit
    import wb_commit_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    wb_commit_if.slave        wb,
    input  logic              pc_valid,
    input  logic [31:0]       pc_data,
    input  logic              rb_busy,
    output logic              rb_we,
    output logic [3:0]        rb_addr,
    output logic [31:0]       rb_data,
    output logic              rb_cpsr_we,
    output logic [31:0]       rb_cpsr,
    output logic              rb_pc_we,
    output logic [31:0]       rb_pc,
    input  logic [3:0]        q_addr,
    output logic              q_hit,
    output logic [31:0]       q_data,
    output logic [CNT_W-1:0]  count,
    output logic              empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    wb_entry_t                      in_entry;
    wb_entry_t                      head_entry;
    logic [ENTRY_W-1:0]             head_raw;
    logic [PTR_W-1:0]               head_ptr;
    logic [CNT_W-1:0]               cnt;
    logic [DEPTH-1:0]               ent_valid;
    logic [DEPTH-1:0][ENTRY_W-1:0]  ents;
    logic                           push;
    logic                           pop;

    logic        rb_we_q,      rb_we_d;
    logic [3:0]  rb_addr_q,    rb_addr_d;
    logic [31:0] rb_data_q,    rb_data_d;
    logic        rb_cpsr_we_q, rb_cpsr_we_d;
    logic [31:0] rb_cpsr_q,    rb_cpsr_d;
    logic        rb_pc_we_q,   rb_pc_we_d;
    logic [31:0] rb_pc_q,      rb_pc_d;

    // Pack the incoming writeback result into a queue entry.
    always_comb begin
        in_entry.cpsr_en = wb.wb_cpsr_en;
        in_entry.cpsr    = wb.wb_cpsr;
        in_entry.reg_en  = wb.wb_reg_en;
        in_entry.addr    = wb.wb_addr;
        in_entry.data    = wb.wb_data;
    end

    // Ready comes from registered occupancy only, so it never depends on wb_valid.
    assign wb.wb_ready = (cnt < CNT_W'(DEPTH));
    assign push        = wb.wb_valid && wb.wb_ready && entry_live(in_entry);
    assign head_entry  = wb_entry_t'(head_raw);
    assign pop         = (cnt != '0) && !rb_busy && !pc_conflict(head_entry, pc_valid);

    wb_commit_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (in_entry),
        .pop_i       (pop),
        .head_data_o (head_raw),
        .head_o      (head_ptr),
        .count_o     (cnt),
        .valid_o     (ent_valid),
        .entries_o   (ents)
    );

    // Next-state for the register-bank output register and the PC path.
    always_comb begin
        rb_we_d      = 1'b0;
        rb_cpsr_we_d = 1'b0;
        rb_addr_d    = rb_addr_q;
        rb_data_d    = rb_data_q;
        rb_cpsr_d    = rb_cpsr_q;
        if (pop) begin
            rb_we_d      = head_entry.reg_en;
            rb_cpsr_we_d = head_entry.cpsr_en;
            rb_addr_d    = head_entry.addr;
            rb_data_d    = head_entry.data;
            rb_cpsr_d    = head_entry.cpsr;
        end
        rb_pc_we_d = pc_valid;
        rb_pc_d    = pc_valid ? pc_data : rb_pc_q;
    end

    // Output register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rb_we_q      <= 1'b0;
            rb_addr_q    <= '0;
            rb_data_q    <= '0;
            rb_cpsr_we_q <= 1'b0;
            rb_cpsr_q    <= '0;
            rb_pc_we_q   <= 1'b0;
            rb_pc_q      <= '0;
        end else begin
            rb_we_q      <= rb_we_d;
            rb_addr_q    <= rb_addr_d;
            rb_data_q    <= rb_data_d;
            rb_cpsr_we_q <= rb_cpsr_we_d;
            rb_cpsr_q    <= rb_cpsr_d;
            rb_pc_we_q   <= rb_pc_we_d;
            rb_pc_q      <= rb_pc_d;
        end
    end

    // Bypass query: youngest matching pending write wins.
    // The output register is the oldest pending write, so it seeds the search;
    // FIFO slots are then walked oldest->youngest so later matches override.
    always_comb begin
        logic [PTR_W-1:0] idx;
        wb_entry_t        e;
        q_hit  = 1'b0;
        q_data = '0;
        idx    = '0;
        e      = '0;
        if (rb_we_q && (rb_addr_q == q_addr)) begin
            q_hit  = 1'b1;
            q_data = rb_data_q;
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head_ptr + PTR_W'(i);
            e   = wb_entry_t'(ents[idx]);
            if (ent_valid[idx] && e.reg_en && (e.addr == q_addr)) begin
                q_hit  = 1'b1;
                q_data = e.data;
            end
        end
    end

    assign rb_we      = rb_we_q;
    assign rb_addr    = rb_addr_q;
    assign rb_data    = rb_data_q;
    assign rb_cpsr_we = rb_cpsr_we_q;
    assign rb_cpsr    = rb_cpsr_q;
    assign rb_pc_we   = rb_pc_we_q;
    assign rb_pc      = rb_pc_q;
    assign count      = cnt;
    assign empty      = (cnt == '0);

endmodule

// File: tb/tb_wb_commit.sv
// Self-checking bench for wb_commit: directed steps plus randomized traffic
// against a queue-based reference model.
module tb_wb_commit;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             pc_valid;
    logic [31:0]      pc_data;
    logic             rb_busy;
    logic             rb_we;
    logic [3:0]       rb_addr;
    logic [31:0]      rb_data;
    logic             rb_cpsr_we;
    logic [31:0]      rb_cpsr;
    logic             rb_pc_we;
    logic [31:0]      rb_pc;
    logic [3:0]       q_addr;
    logic             q_hit;
    logic [31:0]      q_data;
    logic [CNT_W-1:0] count;
    logic             empty;

    wb_commit_if wbif ();

    wb_commit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .wb         (wbif),
        .pc_valid   (pc_valid),
        .pc_data    (pc_data),
        .rb_busy    (rb_busy),
        .rb_we      (rb_we),
        .rb_addr    (rb_addr),
        .rb_data    (rb_data),
        .rb_cpsr_we (rb_cpsr_we),
        .rb_cpsr    (rb_cpsr),
        .rb_pc_we   (rb_pc_we),
        .rb_pc      (rb_pc),
        .q_addr     (q_addr),
        .q_hit      (q_hit),
        .q_data     (q_data),
        .count      (count),
        .empty      (empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  addr;
        logic        reg_en;
        logic [31:0] cpsr;
        logic        cpsr_en;
    } mentry_t;

    // Reference model: list of pending writes in program order plus the
    // last values presented to the register bank.
    mentry_t     mq[$];
    logic        m_we = 1'b0, m_cpsr_we = 1'b0, m_pc_we = 1'b0;
    logic [3:0]  m_addr = '0;
    logic [31:0] m_data = '0, m_cpsr = '0, m_pc = '0;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_wb(input logic v, input logic [3:0] a, input logic [31:0] d,
                            input logic ren, input logic [31:0] c, input logic cen);
        wbif.wb_valid   = v;
        wbif.wb_addr    = a;
        wbif.wb_data    = d;
        wbif.wb_reg_en  = ren;
        wbif.wb_cpsr    = c;
        wbif.wb_cpsr_en = cen;
    endtask

    // Check combinational outputs against the model, advance the model by
    // one clock using the current inputs, then check registered outputs.
    task automatic tick();
        mentry_t     e;
        mentry_t     ne;
        logic        ready;
        logic        do_pop;
        logic        hit;
        logic [31:0] qd;
        #1;
        hit = 1'b0;
        qd  = '0;
        if (m_we && m_addr == q_addr) begin
            hit = 1'b1;
            qd  = m_data;
        end
        foreach (mq[i]) begin
            if (mq[i].reg_en && mq[i].addr == q_addr) begin
                hit = 1'b1;
                qd  = mq[i].data;
            end
        end
        chk("q_hit", q_hit, hit);
        chk("q_data", q_data, qd);
        chk("wb_ready", wbif.wb_ready, mq.size() < DEPTH);
        chk("count", count, mq.size());
        chk("empty", empty, mq.size() == 0);

        if (!reset) begin
            mq.delete();
            m_we = 0; m_cpsr_we = 0; m_pc_we = 0;
            m_addr = '0; m_data = '0; m_cpsr = '0; m_pc = '0;
        end else begin
            ready  = mq.size() < DEPTH;
            do_pop = (mq.size() > 0) && !rb_busy &&
                     !(mq[0].reg_en && mq[0].addr == 4'd15 && pc_valid);
            m_we      = 1'b0;
            m_cpsr_we = 1'b0;
            if (do_pop) begin
                e         = mq.pop_front();
                m_we      = e.reg_en;
                m_cpsr_we = e.cpsr_en;
                m_addr    = e.addr;
                m_data    = e.data;
                m_cpsr    = e.cpsr;
            end
            m_pc_we = pc_valid;
            if (pc_valid) m_pc = pc_data;
            if (wbif.wb_valid && ready && (wbif.wb_reg_en || wbif.wb_cpsr_en)) begin
                ne.data    = wbif.wb_data;
                ne.addr    = wbif.wb_addr;
                ne.reg_en  = wbif.wb_reg_en;
                ne.cpsr    = wbif.wb_cpsr;
                ne.cpsr_en = wbif.wb_cpsr_en;
                mq.push_back(ne);
            end
        end

        @(posedge clk);
        #1;
        chk("rb_we", rb_we, m_we);
        chk("rb_addr", rb_addr, m_addr);
        chk("rb_data", rb_data, m_data);
        chk("rb_cpsr_we", rb_cpsr_we, m_cpsr_we);
        chk("rb_cpsr", rb_cpsr, m_cpsr);
        chk("rb_pc_we", rb_pc_we, m_pc_we);
        chk("rb_pc", rb_pc, m_pc);
    endtask

    initial begin
        reset    = 1'b0;
        pc_valid = 1'b0;
        pc_data  = '0;
        rb_busy  = 1'b0;
        q_addr   = '0;
        drive_wb(0, 4'd0, 32'h0, 0, 32'h0, 0);

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_rb_we", rb_we, 1'b0);
        chk("rst_rb_cpsr_we", rb_cpsr_we, 1'b0);
        chk("rst_rb_pc_we", rb_pc_we, 1'b0);
        chk("rst_rb_data", rb_data, 32'h0);
        chk("rst_rb_pc", rb_pc, 32'h0);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_wb_ready", wbif.wb_ready, 1'b1);
        chk("rst_q_hit", q_hit, 1'b0);
        reset = 1'b1;

        // Single write: rb_we one cycle, two edges after accept
        drive_wb(1, 4'd3, 32'hDEADBEEF, 1, 32'h0, 0);
        tick();
        chk("t1_no_early_we", rb_we, 1'b0);
        drive_wb(0, 4'd0, 32'h0, 0, 32'h0, 0);
        tick();
        chk("t1_we", rb_we, 1'b1);
        chk("t1_addr", rb_addr, 4'd3);
        chk("t1_data", rb_data, 32'hDEADBEEF);
        tick();
        chk("t1_we_off", rb_we, 1'b0);
        chk("t1_empty", empty, 1'b1);

        // Fill while bank busy, then drain in order
        rb_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_wb(1, 4'(i + 1), 32'hA0 + 32'(i), 1, 32'h0, 0);
            tick();
        end
        chk("t2_full_count", count, 4);
        chk("t2_full_ready", wbif.wb_ready, 1'b0);
        drive_wb(1, 4'd9, 32'hBAD, 1, 32'h0, 0);
        tick();
        chk("t2_fifth_rejected", count, 4);
        drive_wb(0, 4'd0, 32'h0, 0, 32'h0, 0);
        rb_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_drain_we", rb_we, 1'b1);
            chk("t2_drain_data", rb_data, 32'hA0 + 32'(i));
        end
        chk("t2_ready_after", wbif.wb_ready, 1'b1);
        tick();
        chk("t2_no_extra", rb_we, 1'b0);

        // PC port alongside a queued write to r15
        drive_wb(1, 4'd15, 32'h100, 1, 32'h0, 0);
        pc_valid = 1'b1;
        pc_data  = 32'h200;
        tick();
        chk("t3_pc_we", rb_pc_we, 1'b1);
        chk("t3_pc", rb_pc, 32'h200);
        drive_wb(0, 4'd0, 32'h0, 0, 32'h0, 0);
        pc_valid = 1'b0;
        tick();
        chk("t3_we", rb_we, 1'b1);
        chk("t3_addr", rb_addr, 4'd15);
        chk("t3_data", rb_data, 32'h100);
        chk("t3_pc_we_off", rb_pc_we, 1'b0);

        // PC conflict stall: r15 at head waits while fetch updates the PC
        drive_wb(1, 4'd15, 32'h300, 1, 32'h0, 0);
        tick();
        drive_wb(0, 4'd0, 32'h0, 0, 32'h0, 0);
        pc_valid = 1'b1;
        pc_data  = 32'h400;
        tick();
        chk("t3s_stalled", rb_we, 1'b0);
        chk("t3s_pc", rb_pc, 32'h400);
        pc_valid = 1'b0;
        tick();
        chk("t3s_we", rb_we, 1'b1);
        chk("t3s_data", rb_data, 32'h300);

        // Query returns youngest pending write
        rb_busy = 1'b1;
        drive_wb(1, 4'd5, 32'h11, 1, 32'h0, 0);
        tick();
        drive_wb(1, 4'd5, 32'h22, 1, 32'h0, 0);
        tick();
        drive_wb(0, 4'd0, 32'h0, 0, 32'h0, 0);
        q_addr = 4'd5;
        #1;
        chk("t4_hit", q_hit, 1'b1);
        chk("t4_data", q_data, 32'h22);
        q_addr = 4'd6;
        #1;
        chk("t4_miss", q_hit, 1'b0);
        chk("t4_miss_data", q_data, 32'h0);
        rb_busy = 1'b0;
        repeat (3) tick();

        // CPSR-only entry
        drive_wb(1, 4'd2, 32'h0, 0, 32'h6000001F, 1);
        tick();
        drive_wb(0, 4'd0, 32'h0, 0, 32'h0, 0);
        tick();
        chk("t5_cpsr_we", rb_cpsr_we, 1'b1);
        chk("t5_cpsr", rb_cpsr, 32'h6000001F);
        chk("t5_we", rb_we, 1'b0);

        // Entry with no enables is accepted but takes no slot
        drive_wb(1, 4'd4, 32'h55, 0, 32'h0, 0);
        tick();
        chk("t5_drop_count", count, 0);
        drive_wb(0, 4'd0, 32'h0, 0, 32'h0, 0);
        tick();

        // Reset mid-operation discards queued writes
        rb_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_wb(1, 4'd7, 32'hC0 + 32'(i), 1, 32'h0, 0);
            tick();
        end
        drive_wb(0, 4'd0, 32'h0, 0, 32'h0, 0);
        chk("t6_count3", count, 3);
        reset = 1'b0;
        tick();
        chk("t6_count0", count, 0);
        chk("t6_we", rb_we, 1'b0);
        chk("t6_cpsr_we", rb_cpsr_we, 1'b0);
        chk("t6_pc_we", rb_pc_we, 1'b0);
        reset   = 1'b1;
        rb_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_no_write", rb_we, 1'b0);
        end

        // Randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            drive_wb($urandom_range(0, 99) < 70, 4'($urandom_range(0, 15)), $urandom,
                     $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) == 0);
            rb_busy  = $urandom_range(0, 99) < 30;
            pc_valid = $urandom_range(0, 99) < 25;
            pc_data  = $urandom;
            q_addr   = 4'($urandom_range(0, 15));
            reset    = $urandom_range(0, 99) != 0;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_commit.md
Name: wb_commit

Overview:
- Clocked commit buffer that sits directly downstream of the writeback stage and feeds the register bank.
- Accepts writeback results (register data/address, CPSR update) through a valid/ready handshake and queues them in a small FIFO.
- Drains one entry per cycle into the register-bank write ports; fetch PC updates go to a separate PC port.
- Provides a combinational pending-write/forwarding query so decode can detect and bypass in-flight register writes.

Parameters:
DEPTH, 4, number of FIFO entries; power of two, 2..16
CNT_W, 3, width of the occupancy counter; must equal log2(DEPTH)+1

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-low reset (sampled on rising edge of clk)
wb_valid  in  1  writeback presents a result this cycle
wb_ready  out  1  buffer can accept; high when count < DEPTH
wb_data  in  32  register write data
wb_addr  in  4  destination register; 15 = PC
wb_reg_en  in  1  entry writes a general register
wb_cpsr  in  32  new CPSR value
wb_cpsr_en  in  1  entry writes CPSR
pc_valid  in  1  fetch PC update request (always accepted)
pc_data  in  32  new PC from fetch
rb_busy  in  1  register bank cannot take a write this cycle
rb_we  out  1  register write strobe
rb_addr  out  4  register write address
rb_data  out  32  register write data
rb_cpsr_we  out  1  CPSR write strobe
rb_cpsr  out  32  CPSR write data
rb_pc_we  out  1  PC write strobe
rb_pc  out  32  PC write data
q_addr  in  4  decode query address
q_hit  out  1  a write to q_addr is pending (FIFO or output register)
q_data  out  32  youngest pending data for q_addr; 0 when no hit
count  out  CNT_W  current FIFO occupancy
empty  out  1  count == 0

Behaviour:
- Reset (reset==0 at a rising edge):
  - head, tail and count are cleared; all entry valid bits are cleared.
  - Registered outputs go to zero: rb_we, rb_cpsr_we, rb_pc_we, rb_addr, rb_data, rb_cpsr, rb_pc.
  - Consequently wb_ready=1, empty=1, q_hit=0.
  - Reset mid-operation discards every queued entry; no strobe is asserted in the cycle following reset.
- Push:
  - Occurs when wb_valid && wb_ready at the edge; the entry {data, addr, reg_en, cpsr, cpsr_en} is written at tail and tail wraps modulo DEPTH.
  - An entry with reg_en=0 and cpsr_en=0 is accepted and dropped; it does not occupy a slot.
  - wb_ready depends only on the registered count, so there is no combinational path from wb_valid.
  - When full, wb_ready=0 even if a pop occurs in the same cycle.
- Pop:
  - Occurs when the FIFO is non-empty and !rb_busy, unless the head has reg_en && addr==15 && pc_valid (PC conflict stall).
  - On a pop, head is loaded into the output register. In the following cycle: rb_we=reg_en, rb_cpsr_we=cpsr_en, with rb_addr, rb_data and rb_cpsr driven from the entry.
  - With no pop, rb_we and rb_cpsr_we are 0; rb_addr, rb_data and rb_cpsr hold their previous values.
- Simultaneous push and pop: count is unchanged; head and tail both advance.
- Minimum latency: 2 cycles, accept edge N to rb_we high in cycle N+2 (the pop happens at edge N+1 when the FIFO was empty before edge N).
- Throughput: one entry per cycle sustained.
- PC port:
  - When pc_valid is sampled, rb_pc_we=1 and rb_pc=pc_data in the next cycle; otherwise rb_pc_we=0.
  - Fetch's PC update takes priority over a queued write to register 15; that write issues on a later cycle and overwrites it (program order).
- rb_busy only blocks pops; it never blocks pc_valid or pushes.
- Query (combinational):
  - Searches the valid FIFO entries with reg_en and addr==q_addr, from youngest to oldest, then the output register if rb_we=1 and rb_addr==q_addr.
  - Returns the first match as q_hit=1 and q_data=its data.
- Wrap-around: head and tail are log2(DEPTH) bits and wrap naturally. Full/empty are derived from count only, never from pointer equality.

Decomposition:
- Shared include wb_commit_defs.vh:
  - Localparams ADDR_PC=4'd15, ENTRY_W=70.
  - Entry field offsets: data[31:0], addr[35:32], reg_en[36], cpsr[68:37], cpsr_en[69].
- One sub-module, wb_commit_fifo: a parameterised circular buffer with push/pop, count, and an exported valid vector plus entry array for the query logic.
- wb_commit itself holds the pop/stall control, the output register, the PC path and the query mux.

Test Plan:
- Reset then push {addr=3, data=0xDEADBEEF, reg_en=1} at edge 1 -> rb_we=1, rb_addr=3, rb_data=0xDEADBEEF in cycle 3 only; empty=1 after.
- Push 4 entries back-to-back with rb_busy=1 -> count=4, wb_ready=0; fifth push is not accepted. Release rb_busy -> 4 consecutive rb_we pulses in FIFO order, then wb_ready=1.
- Queue addr=15 data=0x100 with pc_valid=1, pc_data=0x200 in the same cycle:
  - Next cycle: rb_pc_we=1, rb_pc=0x200.
  - One cycle later: rb_we=1, rb_addr=15, rb_data=0x100.
- Push addr=5 data=0x11 then addr=5 data=0x22, with q_addr=5 and rb_busy=1 -> q_hit=1, q_data=0x22. With q_addr=6 -> q_hit=0, q_data=0.
- Push CPSR-only entry {cpsr_en=1, cpsr=0x6000001F, reg_en=0} -> rb_cpsr_we=1, rb_cpsr=0x6000001F, rb_we=0.
- Fill 3 entries, drive reset=0 for one edge -> count=0 and all strobes 0 the next cycle; no queued write ever appears on rb_*.
